// File: rtl/load_extract_if.sv
// Load request / response bundle between the execute stage, data memory and the load aligner.
// master drives requests and memory data; slave (load_extract) returns the extracted result.
interface load_extract_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [2:0]        req_funct3;
    logic [1:0]        req_addr_lo;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              misalign_err;

    modport master (
        output req_valid, req_funct3, req_addr_lo, stall, flush, mem_rdata,
        input  rsp_valid, rsp_data, misalign_err
    );

    modport slave (
        input  req_valid, req_funct3, req_addr_lo, stall, flush, mem_rdata,
        output rsp_valid, rsp_data, misalign_err
    );
endinterface

// File: rtl/load_extract.sv
// RV32I load aligner: selects/extends the byte, half or word one cycle after the request,
// holding the result while stalled. Define LOAD_MISALIGN_CHECK_EN to flag misaligned LH/LHU/LW.
module load_extract #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    load_extract_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              capture;
    logic [2:0]        funct3_p1;
    logic [1:0]        addr_lo_p1;
    logic [DATA_W-1:0] ext_data_p1;
    logic              ext_err_p1;
    logic [DATA_W-1:0] hold_data_p2;
    logic              hold_err_p2;

    function automatic logic [DATA_W-1:0] extract_load(
        input logic [DATA_W-1:0] word,
        input logic [2:0]        f3,
        input logic [1:0]        off
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [DATA_W-1:0]  res;
        byte_s = word[{off, 3'b000} +: 8];
        half_s = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{(DATA_W-8){byte_s[7]}}, byte_s};
            3'b100:  res = {{(DATA_W-8){1'b0}}, byte_s};
            3'b001:  res = {{(DATA_W-16){half_s[15]}}, half_s};
            3'b101:  res = {{(DATA_W-16){1'b0}}, half_s};
            default: res = word;
        endcase
        return res;
    endfunction

    assign accept  = bus.req_valid && !bus.stall && !bus.flush;
    assign capture = (state == RESP) && bus.stall && !bus.flush;

`ifdef LOAD_MISALIGN_CHECK_EN
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3)
            3'b001, 3'b101: return off[0];
            3'b010:         return off != 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

    // A misaligned load returns zero data with the error flag raised.
    always_comb begin
        ext_err_p1  = is_misaligned(funct3_p1, addr_lo_p1);
        ext_data_p1 = ext_err_p1 ? '0 : extract_load(bus.mem_rdata, funct3_p1, addr_lo_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_err_p2 <= 1'b0;
        end else if (capture) begin
            hold_err_p2 <= ext_err_p1;
        end
    end
`else
    assign ext_data_p1 = extract_load(bus.mem_rdata, funct3_p1, addr_lo_p1);
    assign ext_err_p1  = 1'b0;
    assign hold_err_p2 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = accept ? RESP : IDLE;
                RESP:    state_nxt = bus.stall ? HOLD : (accept ? RESP : IDLE);
                HOLD:    state_nxt = bus.stall ? HOLD : (accept ? RESP : IDLE);
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: request attributes; p1 -> p2: result frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_p1    <= '0;
            addr_lo_p1   <= '0;
            hold_data_p2 <= '0;
        end else begin
            if (accept) begin
                funct3_p1  <= bus.req_funct3;
                addr_lo_p1 <= bus.req_addr_lo;
            end
            if (capture) begin
                hold_data_p2 <= ext_data_p1;
            end
        end
    end

    always_comb begin
        bus.rsp_valid    = 1'b0;
        bus.rsp_data     = '0;
        bus.misalign_err = 1'b0;
        case (state)
            RESP: begin
                bus.rsp_valid    = 1'b1;
                bus.rsp_data     = ext_data_p1;
                bus.misalign_err = ext_err_p1;
            end
            HOLD: begin
                bus.rsp_valid    = 1'b1;
                bus.rsp_data     = hold_data_p2;
                bus.misalign_err = hold_err_p2;
            end
            default: begin
                bus.rsp_valid    = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_load_extract.sv
// Bench for load_extract: streamed vector table with a response scoreboard, then
// hand-written stall/hold, flush and reset-in-hold sequences.
module tb_load_extract;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    load_extract_if bus ();

    load_extract dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] WA = 32'h823456F8;
    localparam logic [31:0] WB = 32'h7F8001FE;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // mis marks loads the optional check flags; ex is the unchecked extraction result
    task automatic add(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd,
                       input logic [31:0] ex, input logic mis);
        vec_t v;
        v.f3    = f3;
        v.off   = off;
        v.rdata = rd;
`ifdef LOAD_MISALIGN_CHECK_EN
        v.exp_data = mis ? 32'h0 : ex;
        v.exp_err  = mis;
`else
        v.exp_data = ex;
        v.exp_err  = 1'b0;
`endif
        vecs.push_back(v);
    endtask

    task automatic drive(input logic vld, input logic [2:0] f3, input logic [1:0] off,
                         input logic stl, input logic fl, input logic [31:0] rd);
        @(posedge clk);
        #1;
        bus.req_valid   = vld;
        bus.req_funct3  = f3;
        bus.req_addr_lo = off;
        bus.stall       = stl;
        bus.flush       = fl;
        bus.mem_rdata   = rd;
    endtask

    task automatic monitor();
        rsp_t e;
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 data=%08h expected rsp_valid=0", bus.rsp_data);
            end else begin
                e = sb.pop_front();
                chk("tbl_rsp_data", bus.rsp_data, e.data);
                chk("tbl_misalign_err", {31'b0, bus.misalign_err}, {31'b0, e.err});
            end
        end else begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                e = sb.pop_front();
                $display("FAIL missing_rsp: got rsp_valid=0 expected rsp_valid=1 data=%08h", e.data);
            end
            chk("idle_rsp_data", bus.rsp_data, 32'h0);
            chk("idle_misalign_err", {31'b0, bus.misalign_err}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_funct3  = 3'b000;
        bus.req_addr_lo = 2'b00;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.mem_rdata   = 32'h0;

        add(3'b000, 2'd0, WA, 32'hFFFFFFF8, 1'b0);
        add(3'b100, 2'd3, WA, 32'h00000082, 1'b0);
        add(3'b001, 2'd2, WA, 32'hFFFF8234, 1'b0);
        add(3'b101, 2'd2, WA, 32'h00008234, 1'b0);
        add(3'b000, 2'd1, WA, 32'h00000056, 1'b0);
        add(3'b000, 2'd3, WA, 32'hFFFFFF82, 1'b0);
        add(3'b100, 2'd0, WA, 32'h000000F8, 1'b0);
        add(3'b001, 2'd0, WA, 32'h000056F8, 1'b0);
        add(3'b010, 2'd0, WA, 32'h823456F8, 1'b0);
        add(3'b011, 2'd2, WA, 32'h823456F8, 1'b0);
        add(3'b110, 2'd1, WA, 32'h823456F8, 1'b0);
        add(3'b111, 2'd3, WB, 32'h7F8001FE, 1'b0);
        add(3'b000, 2'd2, WB, 32'hFFFFFF80, 1'b0);
        add(3'b100, 2'd2, WB, 32'h00000080, 1'b0);
        add(3'b001, 2'd0, WB, 32'h000001FE, 1'b0);
        add(3'b101, 2'd2, WB, 32'h00007F80, 1'b0);
        add(3'b000, 2'd0, WB, 32'hFFFFFFFE, 1'b0);
        add(3'b010, 2'd1, WA, 32'h823456F8, 1'b1);
        add(3'b001, 2'd1, WA, 32'h000056F8, 1'b1);
        add(3'b101, 2'd3, WA, 32'h00008234, 1'b1);
        add(3'b010, 2'd2, WB, 32'h7F8001FE, 1'b1);
        add(3'b001, 2'd3, WB, 32'h00007F80, 1'b1);
        add(3'b101, 2'd1, WB, 32'h000001FE, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("rst_data", bus.rsp_data, 32'h0);
        chk("rst_err", {31'b0, bus.misalign_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streamed back-to-back table: response k-1 is checked while request k is issued
        for (int k = 0; k <= vecs.size(); k++) begin
            if (k < vecs.size())
                drive(1'b1, vecs[k].f3, vecs[k].off, 1'b0, 1'b0, (k > 0) ? vecs[k-1].rdata : 32'hDEADBEEF);
            else
                drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, vecs[k-1].rdata);
            @(negedge clk);
            monitor();
            if (k < vecs.size()) begin
                rsp_t r;
                r.data = vecs[k].exp_data;
                r.err  = vecs[k].exp_err;
                sb.push_back(r);
            end
        end
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, WA);
        @(negedge clk);
        monitor();

        // LW then 3 stall cycles with memory data changing: held result for 4 cycles
        drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("stall_req_valid", {31'b0, bus.rsp_valid}, 32'h0);
        drive(1'b0, 3'b000, 2'd0, 1'b1, 1'b0, WA);
        @(negedge clk);
        chk("stall_c1_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("stall_c1_data", bus.rsp_data, WA);
        for (int c = 2; c <= 3; c++) begin
            drive(1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            chk("stall_hold_valid", {31'b0, bus.rsp_valid}, 32'h1);
            chk("stall_hold_data", bus.rsp_data, WA);
        end
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("stall_c4_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("stall_c4_data", bus.rsp_data, WA);
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, WA);
        @(negedge clk);
        chk("stall_after_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("stall_after_data", bus.rsp_data, 32'h0);

        // Flush together with a new request at N+1 kills it
        drive(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 3'b100, 2'd3, 1'b0, 1'b1, WA);
        @(negedge clk);
        chk("flush_n1_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("flush_n1_data", bus.rsp_data, 32'hFFFFFFF8);
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, WA);
        @(negedge clk);
        chk("flush_n2_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("flush_n2_data", bus.rsp_data, 32'h0);

        // Reset asserted mid-HOLD clears outputs immediately; next load after release is normal
        drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 3'b000, 2'd0, 1'b1, 1'b0, WA);
        drive(1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("rsthold_pre_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("rsthold_pre_data", bus.rsp_data, WA);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rsthold_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("rsthold_data", bus.rsp_data, 32'h0);
        chk("rsthold_err", {31'b0, bus.misalign_err}, 32'h0);
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, WA);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 3'b000, 2'd1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("postrst_req_valid", {31'b0, bus.rsp_valid}, 32'h0);
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, WA);
        @(negedge clk);
        chk("postrst_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("postrst_data", bus.rsp_data, 32'h00000056);
        drive(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, WA);
        @(negedge clk);
        chk("postrst_idle", {31'b0, bus.rsp_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_extract.md
LOAD_EXTRACT -- requirements
Module: load_extract

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge, sole clock); rst_n input 1 (asynchronous assert, active-low).
REQ-002 req_valid  input  1  load request issued this cycle (synchronous memory read launched same cycle).
REQ-003 req_funct3  input  3  RV32I load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-004 req_addr_lo  input  2  byte offset, address bits [1:0].
REQ-005 stall  input  1  downstream pipeline hold; requests are not accepted and responses are not consumed while high.
REQ-006 flush  input  1  synchronous kill of any accepted/pending load.
REQ-007 mem_rdata  input  32  synchronous memory read word, valid the cycle after the request.
REQ-008 rsp_valid  output  1  extracted load result present.
REQ-009 rsp_data  output  32  aligned, extended load result.
REQ-010 misalign_err  output  1  qualifies rsp_valid; misaligned access flag.

Function
REQ-011 A request SHALL be accepted at cycle N iff req_valid=1, stall=0 and flush=0; funct3 and addr_lo SHALL be registered on acceptance.
REQ-012 States SHALL be IDLE, RESP and HOLD.
REQ-013 IDLE goes to RESP on acceptance; otherwise it stays in IDLE.
REQ-014 RESP with stall=0 goes to RESP on a new acceptance, else to IDLE.
REQ-015 RESP with stall=1 goes to HOLD.
REQ-016 HOLD with stall=0 goes to RESP on acceptance, else to IDLE.
REQ-017 HOLD with stall=1 stays in HOLD.
REQ-018 Latency SHALL be one cycle: rsp_valid=1 in every cycle the state is RESP or HOLD, first at N+1.
REQ-019 In RESP, rsp_data SHALL be computed combinationally from the current mem_rdata and the registered funct3/addr_lo.
REQ-020 On RESP->HOLD, the extracted result and error flag SHALL be captured into a hold register; in HOLD, rsp_data/misalign_err SHALL come from that register, stable regardless of mem_rdata.
REQ-021 Byte loads SHALL select byte addr_lo, i.e. mem_rdata[8*addr_lo+7 : 8*addr_lo]; LB sign-extends bit 7 of the byte, LBU zero-extends.
REQ-022 Halfword loads SHALL select the half given by addr_lo[1] (bits [15:0] or [31:16]); LH sign-extends, LHU zero-extends.
REQ-023 LW, and funct3 011/110/111, SHALL return mem_rdata unmodified.
REQ-024 Back-to-back accepted requests SHALL yield back-to-back responses with no bubble.
REQ-025 flush SHALL have priority over req_valid and stall: next state IDLE, so rsp_valid=0 the cycle after flush.
REQ-026 When rsp_valid=0, rsp_data SHALL be 0 and misalign_err SHALL be 0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, clear the hold register and registered funct3/addr_lo, and drive rsp_valid=0, rsp_data=0, misalign_err=0.
REQ-028 Reset during RESP or HOLD SHALL discard the pending result; the first acceptance after rst_n rises SHALL respond normally at N+1.

Configuration
REQ-029 With LOAD_MISALIGN_CHECK_EN defined, a load SHALL be flagged misaligned when it is LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
REQ-030 With LOAD_MISALIGN_CHECK_EN defined, a misaligned response SHALL drive misalign_err=1 and rsp_data=0, with the same timing and hold behaviour as a normal response.
REQ-031 Without LOAD_MISALIGN_CHECK_EN, misalign_err SHALL be tied 0 and no check logic synthesized; halfword loads use addr_lo[1] and ignore addr_lo[0], and word loads ignore addr_lo.

Verification
REQ-032 The bench SHALL cover LB at addr_lo=0 with mem_rdata=0x823456F8 at N+1 -> rsp_valid=1 and rsp_data=0xFFFFFFF8 at N+1; LBU at addr_lo=3 -> 0x00000082.
REQ-033 The bench SHALL cover LH then LHU at addr_lo=2, back-to-back, mem_rdata=0x823456F8 -> rsp_data=0xFFFF8234, then 0x00008234, on consecutive cycles.
REQ-034 The bench SHALL cover LW at addr_lo=0, then stall=1 for 3 cycles with mem_rdata changed to 0 -> rsp_valid=1 and rsp_data=0x823456F8 in all 4 cycles, then IDLE.
REQ-035 The bench SHALL cover LW at addr_lo=1 with LOAD_MISALIGN_CHECK_EN defined -> misalign_err=1, rsp_data=0; without the macro -> misalign_err=0, rsp_data=mem_rdata.
REQ-036 The bench SHALL cover flush=1 at N+1 together with req_valid=1 -> rsp_valid=0 at N+2.
REQ-037 The bench SHALL cover rst_n=0 mid-HOLD -> all outputs 0 immediately; a new LB after reset releases -> correct response at N+1.
